// File: rtl/dmem_mshr_ctrl_pkg.sv
// dmem_mshr_ctrl_pkg: shared bus message, memory command and sizing constants
package dmem_mshr_ctrl_pkg;
  typedef enum logic [1:0] {NONE, GET_S, GET_M, PUT_M} message_t;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int XLEN = 64;
  localparam int LINE_OFS = 3;
  localparam int TAG_W = 4;
  localparam int DEF_ISS_DEPTH = 4;
  localparam int DEF_RSP_DEPTH = 4;
  localparam int DEF_PTR_W = 3;
  localparam int DEF_LINES = 8192;
endpackage

// File: rtl/dmem_mshr_ctrl_rsp_cam.sv
// dmem_rsp_cam: outstanding-load table mapping memory tags to bus response slots
module dmem_rsp_cam
  import dmem_mshr_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_RSP_DEPTH,
  parameter int PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [PTR_W-1:0] alloc_ptr,
  input  logic [TAG_W-1:0] rtn_tag,
  output logic             hit,
  output logic [PTR_W-1:0] hit_ptr,
  output logic             full
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DEPTH-1:0] vld;
  logic [TAG_W-1:0] tag [DEPTH];
  logic [PTR_W-1:0] ptr [DEPTH];
  logic [IW-1:0] hit_idx, free_idx;
  // lowest matching slot answers a return; lowest empty slot takes the next load
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && rtn_tag != '0 && tag[i] == rtn_tag) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!vld[i]) free_idx = IW'(i);
    end
  end
  assign hit_ptr = ptr[hit_idx];
  assign full = &vld;
  // a return frees its slot in the same cycle it is reported
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (hit) vld[hit_idx] <= 1'b0;
      if (alloc && !full) begin
        vld[free_idx] <= 1'b1;
        tag[free_idx] <= alloc_tag;
        ptr[free_idx] <= alloc_ptr;
      end
    end
  end
endmodule

// File: rtl/dmem_mshr_ctrl.sv
// dmem_mshr_ctrl: memory-side coherence controller with issue queue, store forwarding and coalescing
module dmem_mshr_ctrl
  import dmem_mshr_ctrl_pkg::*;
#(
  parameter int ISS_DEPTH = DEF_ISS_DEPTH,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH,
  parameter int PTR_W = DEF_PTR_W,
  parameter int LINES = DEF_LINES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  bus_req_addr_i,
  input  message_t         bus_req_message_i,
  input  logic [XLEN-1:0]  bus_req_data_i,
  input  logic [PTR_W-1:0] bus_req_ptr_i,
  input  logic             bus_req_core_ack_i,
  input  logic             bus_req_ack_i,
  input  logic             bus_rsp_vld_i,
  input  logic [XLEN-1:0]  bus_rsp_addr_i,
  input  logic [XLEN-1:0]  bus_rsp_data_i,
  output logic             ctrl_rsp_ack_o,
  output logic             ctrl_rsp_vld_o,
  output logic [PTR_W-1:0] ctrl_rsp_ptr_o,
  output logic [XLEN-1:0]  ctrl_rsp_data_o,
  input  logic [3:0]       Dmem2proc_response_i,
  input  logic [XLEN-1:0]  Dmem2proc_data_i,
  input  logic [3:0]       Dmem2proc_tag_i,
  output logic [XLEN-1:0]  proc2Dmem_addr_o,
  output logic [XLEN-1:0]  proc2Dmem_data_o,
  output logic [1:0]       proc2Dmem_command_o
);
  localparam int IW = $clog2(ISS_DEPTH);
  localparam int LW = $clog2(LINES);
  typedef struct packed {
    logic vld;
    logic rdy;
    logic st;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [PTR_W-1:0] ptr;
  } ent_t;
  ent_t q [ISS_DEPTH];
  ent_t head;
  logic [IW:0] wp, rp;
  logic [IW-1:0] k, coal_idx;
  logic [LINES-1:0] dirty;
  logic [LW-1:0] line;
  logic fwd_vld;
  logic [PTR_W-1:0] fwd_ptr, cam_ptr;
  logic [XLEN-1:0] fwd_data, fwd_d;
  logic full, stall, accept, cam_full, cam_hit, commit, alloc_now;
  logic fwd_hit, coal_hit, alloc, alloc_st, alloc_rdy, set_dirty, clr_dirty, do_fwd, do_coal;
  assign line = bus_req_addr_i[LINE_OFS +: LW];
  assign full = wp[IW-1:0] == rp[IW-1:0] && wp[IW] != rp[IW];
  assign head = q[rp[IW-1:0]];
  assign proc2Dmem_command_o = head.vld && head.rdy && (head.st || !cam_full) ? (head.st ? BUS_STORE : BUS_LOAD) : BUS_NONE;
  assign proc2Dmem_addr_o = head.addr;
  assign proc2Dmem_data_o = head.data;
  assign accept = Dmem2proc_response_i != '0 && proc2Dmem_command_o != BUS_NONE;
  assign stall = full && !accept;
  // scan oldest to youngest so the youngest ready store to this address wins
  always_comb begin
    k = '0;
    fwd_hit = 1'b0;
    fwd_d = '0;
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < ISS_DEPTH; i++) begin
      k = IW'(rp[IW-1:0] + IW'(i));
      if (q[k].vld && q[k].rdy && q[k].st && q[k].addr == bus_req_addr_i) begin
        fwd_hit = 1'b1;
        fwd_d = q[k].data;
        if (i != 0) begin
          coal_hit = 1'b1;
          coal_idx = k;
        end
      end
    end
  end
  // request decode: acknowledge and decide what a committed request does
  always_comb begin
    ctrl_rsp_ack_o = 1'b0;
    alloc = 1'b0;
    alloc_st = 1'b0;
    alloc_rdy = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    do_fwd = 1'b0;
    do_coal = 1'b0;
    if (bus_req_message_i == PUT_M && coal_hit) begin
      ctrl_rsp_ack_o = 1'b1;
      do_coal = 1'b1;
      clr_dirty = 1'b1;
    end else if (!dirty[line]) begin
      if (bus_req_message_i == GET_M) begin
        ctrl_rsp_ack_o = 1'b1;
        set_dirty = 1'b1;
      end else if (bus_req_message_i == GET_S && !bus_req_core_ack_i) begin
        ctrl_rsp_ack_o = !stall && !(fwd_hit && fwd_vld);
        do_fwd = fwd_hit;
        alloc = !fwd_hit;
        alloc_rdy = 1'b1;
      end
    end else if (bus_req_message_i == PUT_M || bus_req_message_i == GET_S) begin
      ctrl_rsp_ack_o = !stall;
      alloc = 1'b1;
      alloc_st = bus_req_message_i == PUT_M || bus_req_core_ack_i;
      alloc_rdy = bus_req_message_i == PUT_M || !bus_req_core_ack_i;
      clr_dirty = 1'b1;
    end else if (bus_req_message_i == GET_M) begin
      ctrl_rsp_ack_o = 1'b1;
    end
  end
  assign commit = bus_req_ack_i && ctrl_rsp_ack_o;
  assign alloc_now = commit && alloc;
  // memory returns take the response port; the forward buffer drains otherwise
  assign ctrl_rsp_vld_o = cam_hit || fwd_vld;
  assign ctrl_rsp_ptr_o = cam_hit ? cam_ptr : fwd_ptr;
  assign ctrl_rsp_data_o = cam_hit ? Dmem2proc_data_i : fwd_data;
  dmem_rsp_cam #(.DEPTH(RSP_DEPTH), .PTR_W(PTR_W)) u_cam (
    .clk(clk),
    .rst(rst),
    .alloc(accept && !head.st),
    .alloc_tag(Dmem2proc_response_i),
    .alloc_ptr(head.ptr),
    .rtn_tag(Dmem2proc_tag_i),
    .hit(cam_hit),
    .hit_ptr(cam_ptr),
    .full(cam_full)
  );
  // queue, dirty-bit and forward-buffer state; owner data lands last so it overrides
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      dirty <= '0;
      fwd_vld <= 1'b0;
      fwd_ptr <= '0;
      fwd_data <= '0;
      for (int i = 0; i < ISS_DEPTH; i++) q[i] <= '0;
    end else begin
      if (commit && set_dirty) dirty[line] <= 1'b1;
      if (commit && clr_dirty) dirty[line] <= 1'b0;
      if (accept) begin
        q[rp[IW-1:0]].vld <= 1'b0;
        rp <= rp + 1'b1;
      end
      if (alloc_now) begin
        q[wp[IW-1:0]] <= '{vld: 1'b1, rdy: alloc_rdy, st: alloc_st, addr: bus_req_addr_i, data: bus_req_data_i, ptr: bus_req_ptr_i};
        wp <= wp + 1'b1;
      end
      if (commit && do_coal) q[coal_idx].data <= bus_req_data_i;
      if (commit && do_fwd) begin
        fwd_vld <= 1'b1;
        fwd_ptr <= bus_req_ptr_i;
        fwd_data <= fwd_d;
      end else if (fwd_vld && !cam_hit) begin
        fwd_vld <= 1'b0;
      end
      for (int i = 0; i < ISS_DEPTH; i++)
        if (bus_rsp_vld_i && q[i].vld && q[i].addr == bus_rsp_addr_i && !(alloc_now && IW'(i) == wp[IW-1:0])) begin
          q[i].rdy <= 1'b1;
          q[i].data <= bus_rsp_data_i;
        end
      if (alloc_now && bus_rsp_vld_i && bus_rsp_addr_i == bus_req_addr_i) begin
        q[wp[IW-1:0]].rdy <= 1'b1;
        q[wp[IW-1:0]].data <= bus_rsp_data_i;
      end
    end
  end
endmodule

// File: tb/tb_dmem_mshr_ctrl.sv
// tb_dmem_mshr_ctrl: scoreboard bench for loads, reordered returns, coalescing, forwarding, full queue and reset
module tb_dmem_mshr_ctrl;
  import dmem_mshr_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] bus_req_addr_i, bus_req_data_i, bus_rsp_addr_i, bus_rsp_data_i, Dmem2proc_data_i;
  message_t bus_req_message_i;
  logic [2:0] bus_req_ptr_i;
  logic bus_req_core_ack_i, bus_req_ack_i, bus_rsp_vld_i;
  logic ctrl_rsp_ack_o, ctrl_rsp_vld_o;
  logic [2:0] ctrl_rsp_ptr_o;
  logic [63:0] ctrl_rsp_data_o, proc2Dmem_addr_o, proc2Dmem_data_o;
  logic [3:0] Dmem2proc_response_i, Dmem2proc_tag_i;
  logic [1:0] proc2Dmem_command_o;
  int n_checks = 0;
  int n_errors = 0;
  typedef struct {logic [2:0] ptr; logic [63:0] data;} rsp_t;
  rsp_t exp_q[$];

  dmem_mshr_ctrl dut (
    .clk(clk), .rst(rst),
    .bus_req_addr_i(bus_req_addr_i), .bus_req_message_i(bus_req_message_i),
    .bus_req_data_i(bus_req_data_i), .bus_req_ptr_i(bus_req_ptr_i),
    .bus_req_core_ack_i(bus_req_core_ack_i), .bus_req_ack_i(bus_req_ack_i),
    .bus_rsp_vld_i(bus_rsp_vld_i), .bus_rsp_addr_i(bus_rsp_addr_i), .bus_rsp_data_i(bus_rsp_data_i),
    .ctrl_rsp_ack_o(ctrl_rsp_ack_o), .ctrl_rsp_vld_o(ctrl_rsp_vld_o),
    .ctrl_rsp_ptr_o(ctrl_rsp_ptr_o), .ctrl_rsp_data_o(ctrl_rsp_data_o),
    .Dmem2proc_response_i(Dmem2proc_response_i), .Dmem2proc_data_i(Dmem2proc_data_i),
    .Dmem2proc_tag_i(Dmem2proc_tag_i),
    .proc2Dmem_addr_o(proc2Dmem_addr_o), .proc2Dmem_data_o(proc2Dmem_data_o),
    .proc2Dmem_command_o(proc2Dmem_command_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // every response the DUT produces must match the oldest expected one
  always @(negedge clk) begin
    if (!rst && ctrl_rsp_vld_o) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(ctrl_rsp_vld_o), 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_ptr", 64'(ctrl_rsp_ptr_o), 64'(e.ptr));
        check("rsp_data", ctrl_rsp_data_o, e.data);
      end
    end
  end

  task automatic idle();
    bus_req_message_i = NONE;
    bus_req_addr_i = '0;
    bus_req_data_i = '0;
    bus_req_ptr_i = '0;
    bus_req_core_ack_i = 1'b0;
    bus_req_ack_i = 1'b0;
    bus_rsp_vld_i = 1'b0;
    bus_rsp_addr_i = '0;
    bus_rsp_data_i = '0;
    Dmem2proc_response_i = '0;
    Dmem2proc_data_i = '0;
    Dmem2proc_tag_i = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input string tag, input message_t m, input logic [63:0] a, input logic [63:0] d,
                     input logic [2:0] p, input logic ca, input logic exp_ack);
    bus_req_message_i = m;
    bus_req_addr_i = a;
    bus_req_data_i = d;
    bus_req_ptr_i = p;
    bus_req_core_ack_i = ca;
    bus_req_ack_i = 1'b1;
    #1 check(tag, 64'(ctrl_rsp_ack_o), 64'(exp_ack));
    cyc();
    idle();
  endtask

  task automatic mem_accept(input string tag, input logic [3:0] t, input logic [1:0] cmd,
                            input logic [63:0] a, input logic [63:0] d, input logic chk_d);
    Dmem2proc_response_i = t;
    #1 check({tag, "_cmd"}, 64'(proc2Dmem_command_o), 64'(cmd));
    check({tag, "_addr"}, proc2Dmem_addr_o, a);
    if (chk_d) check({tag, "_data"}, proc2Dmem_data_o, d);
    cyc();
    idle();
  endtask

  task automatic mem_return(input logic [3:0] t, input logic [2:0] p, input logic [63:0] d);
    exp_q.push_back('{ptr: p, data: d});
    Dmem2proc_tag_i = t;
    Dmem2proc_data_i = d;
    cyc();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_ack", 64'(ctrl_rsp_ack_o), 64'd0);
    check("rst_vld", 64'(ctrl_rsp_vld_o), 64'd0);
    check("rst_cmd", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    check("rst_addr", proc2Dmem_addr_o, 64'd0);
    cyc();
    // single load round trip
    req("ld_ack", GET_S, 64'h100, 64'h0, 3'd5, 1'b0, 1'b1);
    mem_accept("ld", 4'd3, BUS_LOAD, 64'h100, 64'h0, 1'b0);
    check("ld_drained_cmd", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    mem_return(4'd3, 3'd5, 64'hAAAA_0000_0000_0100);
    // two loads returned out of order, plus an unknown tag
    req("ld2a_ack", GET_S, 64'h108, 64'h0, 3'd1, 1'b0, 1'b1);
    req("ld2b_ack", GET_S, 64'h110, 64'h0, 3'd2, 1'b0, 1'b1);
    mem_accept("ld2a", 4'd1, BUS_LOAD, 64'h108, 64'h0, 1'b0);
    mem_accept("ld2b", 4'd2, BUS_LOAD, 64'h110, 64'h0, 1'b0);
    mem_return(4'd2, 3'd2, 64'h2222);
    Dmem2proc_tag_i = 4'd7;
    #1 check("bad_tag_vld", 64'(ctrl_rsp_vld_o), 64'd0);
    cyc();
    idle();
    mem_return(4'd1, 3'd1, 64'h1111);
    // coalescing behind a blocked head
    req("own400", GET_M, 64'h400, 64'h0, 3'd0, 1'b0, 1'b1);
    req("gets400", GET_S, 64'h400, 64'h0, 3'd0, 1'b1, 1'b1);
    check("blocked_cmd", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    req("own200", GET_M, 64'h200, 64'h0, 3'd0, 1'b0, 1'b1);
    req("putA", PUT_M, 64'h200, 64'hA, 3'd0, 1'b0, 1'b1);
    req("putB", PUT_M, 64'h200, 64'hB, 3'd0, 1'b0, 1'b1);
    bus_rsp_vld_i = 1'b1;
    bus_rsp_addr_i = 64'h400;
    bus_rsp_data_i = 64'h0404;
    cyc();
    idle();
    mem_accept("st400", 4'd1, BUS_STORE, 64'h400, 64'h0404, 1'b1);
    mem_accept("st200", 4'd2, BUS_STORE, 64'h200, 64'hB, 1'b1);
    check("coal_one_store", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    // forwarding from a pending store
    req("own300", GET_M, 64'h300, 64'h0, 3'd0, 1'b0, 1'b1);
    req("putC", PUT_M, 64'h300, 64'hC, 3'd0, 1'b0, 1'b1);
    exp_q.push_back('{ptr: 3'd6, data: 64'hC});
    req("fwd_ack", GET_S, 64'h300, 64'h0, 3'd6, 1'b0, 1'b1);
    req("fwd_busy_ack", GET_S, 64'h300, 64'h0, 3'd7, 1'b0, 1'b0);
    mem_accept("st300", 4'd2, BUS_STORE, 64'h300, 64'hC, 1'b1);
    check("fwd_no_load", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    // full issue queue with same-cycle memory accept
    for (int i = 0; i < 4; i++)
      req("fill_ack", GET_S, 64'h508 + 64'(i * 8), 64'h0, 3'(i), 1'b0, 1'b1);
    bus_req_message_i = GET_S;
    bus_req_addr_i = 64'h540;
    bus_req_ptr_i = 3'd4;
    bus_req_ack_i = 1'b1;
    #1 check("full_ack", 64'(ctrl_rsp_ack_o), 64'd0);
    Dmem2proc_response_i = 4'd4;
    #1 check("full_accept_ack", 64'(ctrl_rsp_ack_o), 64'd1);
    check("full_accept_addr", proc2Dmem_addr_o, 64'h508);
    cyc();
    idle();
    mem_accept("f1", 4'd5, BUS_LOAD, 64'h510, 64'h0, 1'b0);
    mem_accept("f2", 4'd6, BUS_LOAD, 64'h518, 64'h0, 1'b0);
    mem_accept("f3", 4'd7, BUS_LOAD, 64'h520, 64'h0, 1'b0);
    check("cam_full_cmd", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    mem_return(4'd5, 3'd1, 64'h5555);
    mem_accept("f4", 4'd8, BUS_LOAD, 64'h540, 64'h0, 1'b0);
    mem_return(4'd4, 3'd0, 64'h4444);
    mem_return(4'd6, 3'd2, 64'h6666);
    mem_return(4'd7, 3'd3, 64'h7777);
    mem_return(4'd8, 3'd4, 64'h8888);
    // reset with a load in flight
    req("own700", GET_M, 64'h700, 64'h0, 3'd0, 1'b0, 1'b1);
    req("ld600", GET_S, 64'h600, 64'h0, 3'd7, 1'b0, 1'b1);
    mem_accept("ld600", 4'd9, BUS_LOAD, 64'h600, 64'h0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_cmd", 64'(proc2Dmem_command_o), 64'(BUS_NONE));
    check("rst2_vld", 64'(ctrl_rsp_vld_o), 64'd0);
    check("rst2_ack", 64'(ctrl_rsp_ack_o), 64'd0);
    req("rst2_dirty_cleared", PUT_M, 64'h700, 64'hE, 3'd0, 1'b0, 1'b0);
    Dmem2proc_tag_i = 4'd9;
    Dmem2proc_data_i = 64'h9999;
    #1 check("stale_tag_vld", 64'(ctrl_rsp_vld_o), 64'd0);
    cyc();
    idle();
    cyc();
    check("rsp_left", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
